dbus_ctrl: RTL and testbench
============================

Name: dbus_ctrl

Overview:
- Sequencer between the memory pipeline stage and the data bus (dbus_req_t / dbus_resp_t).
- Holds each load/store on the bus until data_ok and stalls the pipeline meanwhile.
- Generates byte strobes and aligned write data, extracts and sign/zero-extends load data, and rejects misaligned accesses without a bus transaction.
- Lets a flush abandon an in-flight access cleanly.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  memory stage has a load/store this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  3  msize_t: MSIZE1, MSIZE2, MSIZE4, MSIZE8.
- req_unsigned  in  1  zero-extend load (lbu/lhu/lwu).
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- flush  in  1  discard the current request.
- stall  out  1  freeze the memory stage and everything upstream.
- done  out  1  one-cycle pulse: access finished, rdata valid.
- rdata  out  64  extended load data; 0 for stores.
- misalign  out  1  one-cycle pulse with done: address not size-aligned, no bus access made.
- dreq  out  dbus_req_t  valid, addr, size, strobe, data.
- dresp  in  dbus_resp_t  addr_ok, data_ok, data.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; dreq all zero; stall=0, done=0, misalign=0, rdata=0; drop flag cleared.
  - Reset mid-transaction abandons the transaction; dreq.valid falls immediately.
- State IDLE:
  - req_valid=1, flush=0, aligned: latch addr, size, strobe, data; go BUSY; stall=1.
  - req_valid=1, misaligned: go DONE with misalign=1; no bus access; stall=1 this cycle.
  - Aligned means addr[0]=0 for size 2, addr[1:0]=0 for size 4, addr[2:0]=0 for size 8.
  - flush=1 or req_valid=0: stay IDLE; stall=0.
- State BUSY:
  - dreq.valid=1; addr, size, strobe, data driven from registers and held stable until data_ok.
  - addr_ok is ignored; completion is data_ok only.
  - stall=1.
  - On data_ok=1:
    - Drop flag clear: register extracted rdata; go DONE.
    - Drop flag set: go IDLE; no done pulse; drop flag cleared.
  - flush=1 while BUSY sets the drop flag. The bus transaction is not cancelled.
  - dreq.valid deasserts the cycle after data_ok.
- State DONE:
  - done=1 for exactly one cycle; stall=0 so the pipeline advances; go IDLE.
  - misalign=1 in DONE only when DONE was entered from the misaligned path.
  - flush in DONE has no effect; done still pulses.
- Latency:
  - Request seen in cycle 0; dreq.valid first high in cycle 1.
  - data_ok in cycle k gives done in cycle k+1.
  - Minimum 3 cycles per access (data_ok in cycle 1).
  - A back-to-back request is accepted in the IDLE cycle after DONE.
- Strobe and write data (off = addr[2:0]):
  - strobe is 0x01<<off for size 1, 0x03<<off for size 2, 0x0F<<off for size 4, 0xFF for size 8.
  - dreq.data = req_wdata << (8*off).
  - Loads drive strobe=0.
- Load data:
  - Shift dresp.data right by 8*off, then take the low 8/16/32/64 bits.
  - Extend to 64 bits, signed unless req_unsigned.
- Stores: rdata=0 at done.
- Upstream contract: inputs stay stable while stall=1. The block does not re-sample inputs in BUSY.

Decomposition:
- Shared package pipes gains:
  - dbus_state_t enum: IDLE, BUSY, DONE.
  - mem_req_t struct: write, size, unsigned, addr, wdata.
  - The strobe and extend functions, so writeback can reuse the extension.
- Natural sub-module: mem_align (combinational): size + offset + wdata -> strobe and shifted data; size + offset + unsigned + raw data -> extended data.
- dbus_ctrl holds the FSM, registers and drop flag.

Test Plan:
- Aligned load: ld at addr 0x80000008, dresp.data=0x1122334455667788, data_ok in cycle 3 -> dreq.valid high cycles 1-3, done in cycle 4, rdata=0x1122334455667788, stall high cycles 0-3.
- Sub-word signed and unsigned loads: lb at 0x80000003 with data 0x00000000_80FF0000_ -> byte 0x80 yields rdata=0xFFFFFFFFFFFFFF80; the same access with lbu yields 0x80; lh at offset 6 with top half 0xBEEF yields 0xFFFFFFFFFFFFBEEF.
- Store strobe: sh 0xABCD at 0x80000006 -> strobe=0xC0, dreq.data=0xABCD000000000000, data stable until data_ok, done then rdata=0.
- Misaligned: lw at 0x80000002 -> dreq.valid never rises; done=1 and misalign=1 in cycle 1; stall high only in cycle 0.
- Flush in flight: load accepted, flush pulsed in cycle 2, data_ok in cycle 5 -> dreq.valid held through cycle 5, no done pulse, back in IDLE in cycle 6, next request accepted normally.
- Reset mid-BUSY: resetn low in cycle 2 -> dreq.valid and stall drop asynchronously; after release state is IDLE and a fresh sd completes normally.

Source files
------------

// File: rtl/pipes.sv
// Shared pipeline types: data bus request/response, memory access
// descriptors, and the byte-lane helpers reused by writeback.
package pipes;

    localparam int unsigned DBUS_W = 64;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic              valid;
        logic [DBUS_W-1:0] addr;
        msize_t            size;
        logic [7:0]        strobe;
        logic [DBUS_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DBUS_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dbus_state_t;

    // 'unsigned' is reserved, so the zero-extend flag is unsigned_ld.
    typedef struct packed {
        logic              write;
        msize_t            size;
        logic              unsigned_ld;
        logic [DBUS_W-1:0] addr;
        logic [DBUS_W-1:0] wdata;
    } mem_req_t;

    // Byte lanes touched by an access of the given size at byte offset off.
    function automatic logic [7:0] strobe_of(input msize_t size, input logic [2:0] off);
        logic [7:0] s;
        case (size)
            MSIZE1:  s = 8'h01 << off;
            MSIZE2:  s = 8'h03 << off;
            MSIZE4:  s = 8'h0F << off;
            MSIZE8:  s = 8'hFF;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // True when the low address bits are a multiple of the access size.
    function automatic logic is_aligned(input msize_t size, input logic [2:0] off);
        logic ok;
        case (size)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (off[0] == 1'b0);
            MSIZE4:  ok = (off[1:0] == 2'b00);
            MSIZE8:  ok = (off == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Extend the right-aligned low bytes of raw to 64 bits.
    function automatic logic [DBUS_W-1:0] extend(input msize_t size, input logic uns,
                                                 input logic [DBUS_W-1:0] raw);
        logic [DBUS_W-1:0] v;
        case (size)
            MSIZE1:  v = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            MSIZE2:  v = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            MSIZE4:  v = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            MSIZE8:  v = raw;
            default: v = 64'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dbus_ctrl_mem_align.sv
// Byte-lane alignment: store strobe and shifted write data, and
// right-shift plus extension of raw load data.
module mem_align
    import pipes::*;
(
    input  msize_t      size,
    input  logic [2:0]  off,
    input  logic        uns,
    input  logic [63:0] wdata,
    input  logic [63:0] raw,
    output logic [7:0]  strobe,
    output logic [63:0] wdata_sh,
    output logic [63:0] ext
);

    // Pure lane steering; the offset selects an 8-bit granular shift.
    always_comb begin
        strobe   = strobe_of(size, off);
        wdata_sh = wdata << {off, 3'b000};
        ext      = extend(size, uns, raw >> {off, 3'b000});
    end

endmodule

// File: rtl/dbus_ctrl.sv
// Memory-stage data bus sequencer: holds one load/store on the bus until
// data_ok, stalls the pipeline meanwhile, and rejects misaligned accesses.
module dbus_ctrl
    import pipes::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [2:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            misalign,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp
);

    dbus_state_t     state_r;
    dbus_state_t     state_n_s;
    mem_req_t        req_r;
    mem_req_t        new_req_s;
    logic            mis_r;
    logic            drop_r;
    logic [XLEN-1:0] rdata_r;
    logic            accept_s;
    logic            aligned_s;
    logic            drop_eff_s;
    logic [7:0]      strobe_s;
    logic [63:0]     wdata_sh_s;
    logic [63:0]     ext_s;
    logic            unused_addr_ok_s;

    // Completion is signalled by data_ok alone.
    assign unused_addr_ok_s = dresp.addr_ok;

    mem_align u_align (
        .size     (req_r.size),
        .off      (req_r.addr[2:0]),
        .uns      (req_r.unsigned_ld),
        .wdata    (req_r.wdata),
        .raw      (dresp.data),
        .strobe   (strobe_s),
        .wdata_sh (wdata_sh_s),
        .ext      (ext_s)
    );

    // Decode the incoming request and whether a flush discards the response.
    always_comb begin
        new_req_s             = '0;
        new_req_s.write       = req_write;
        new_req_s.size        = msize_t'(req_size);
        new_req_s.unsigned_ld = req_unsigned;
        new_req_s.addr        = req_addr;
        new_req_s.wdata       = req_wdata;
        aligned_s             = is_aligned(msize_t'(req_size), req_addr[2:0]);
        accept_s              = req_valid && !flush;
        drop_eff_s            = drop_r || flush;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (aligned_s) begin
                        state_n_s = BUSY;
                    end else begin
                        state_n_s = DONE;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            BUSY: begin
                if (dresp.data_ok) begin
                    if (drop_eff_s) begin
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = DONE;
                    end
                end else begin
                    state_n_s = BUSY;
                end
            end
            DONE:    state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // Latched request, misalign/drop flags and the extended load result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_r   <= '0;
            mis_r   <= 1'b0;
            drop_r  <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mis_r   <= !aligned_s;
                        drop_r  <= 1'b0;
                        rdata_r <= '0;
                        if (aligned_s) begin
                            req_r <= new_req_s;
                        end
                    end
                end
                BUSY: begin
                    if (dresp.data_ok) begin
                        drop_r <= 1'b0;
                        if (!drop_eff_s && !req_r.write) begin
                            rdata_r <= ext_s;
                        end
                    end else if (flush) begin
                        drop_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus request and pipeline handshake outputs, all derived from state.
    always_comb begin
        dreq       = '0;
        dreq.valid = (state_r == BUSY);
        dreq.addr  = req_r.addr;
        dreq.size  = req_r.size;
        dreq.data  = wdata_sh_s;
        if (req_r.write) begin
            dreq.strobe = strobe_s;
        end else begin
            dreq.strobe = 8'h00;
        end
        if (!resetn) begin
            stall = 1'b0;
        end else if (state_r == BUSY) begin
            stall = 1'b1;
        end else if (state_r == IDLE && accept_s) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
        done     = (state_r == DONE);
        misalign = (state_r == DONE) && mis_r;
        rdata    = rdata_r;
    end

endmodule

// File: tb/tb_dbus_ctrl.sv
// Self-checking bench for dbus_ctrl: directed scenarios plus randomized
// accesses compared against a byte-level reference model.
module tb_dbus_ctrl;
    import pipes::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        done;
    logic [63:0] rdata;
    logic        misalign;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;

    int n_pass  = 0;
    int n_total = 0;

    dbus_ctrl #(.XLEN(64)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .misalign     (misalign),
        .dreq         (dreq),
        .dresp        (dresp)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Cycle boundary: 1 unit after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte lanes covered by nb bytes starting at lane off.
    function automatic logic [7:0] m_strobe(input int nb, input int off);
        int s;
        s = ((1 << nb) - 1) << off;
        return 8'(s);
    endfunction

    // Reference: write data moved up by off byte positions.
    function automatic logic [63:0] m_wdata(input logic [63:0] w, input int off);
        logic [63:0] t;
        t = w;
        for (int i = 0; i < off; i++) t = t * 64'd256;
        return t;
    endfunction

    // Reference: gather nb bytes from lane off, then extend.
    function automatic logic [63:0] m_load(input logic [63:0] raw, input int nb,
                                           input int off, input logic uns);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(off+i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // One access from the IDLE cycle through completion; data_ok arrives
    // in cycle lat, flush pulses in cycle fl (0 = none).
    task automatic run_access(input string nm, input logic wr, input logic [2:0] sz,
                              input logic uns, input logic [63:0] addr,
                              input logic [63:0] wd, input logic [63:0] raw,
                              input int lat, input int fl);
        int          nb;
        int          off;
        logic        al;
        logic        dropped;
        logic [63:0] exp_rd;
        nb      = 1 << sz;
        off     = int'(addr[2:0]);
        al      = (off % nb) == 0;
        dropped = (fl >= 1) && (fl <= lat);
        exp_rd  = wr ? 64'd0 : m_load(raw, nb, off, uns);

        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        flush        = 1'b0;
        dresp        = '0;
        #2;
        chk({nm, ".stall_c0"}, 64'(stall), 64'd1);
        chk({nm, ".valid_c0"}, 64'(dreq.valid), 64'd0);
        next();

        if (!al) begin
            #2;
            chk({nm, ".mis_done"}, 64'(done), 64'd1);
            chk({nm, ".mis_flag"}, 64'(misalign), 64'd1);
            chk({nm, ".mis_valid"}, 64'(dreq.valid), 64'd0);
            chk({nm, ".mis_stall"}, 64'(stall), 64'd0);
            req_valid = 1'b0;
            next();
            #2;
            chk({nm, ".mis_after"}, 64'({done, misalign, dreq.valid}), 64'd0);
        end else begin
            for (int c = 1; c <= lat; c++) begin
                flush          = (c == fl);
                dresp.data_ok  = (c == lat);
                dresp.addr_ok  = 1'($urandom_range(0, 1));
                dresp.data     = (c == lat) ? raw : {$urandom, $urandom};
                #2;
                chk({nm, ".busy_valid"}, 64'(dreq.valid), 64'd1);
                chk({nm, ".busy_stall"}, 64'(stall), 64'd1);
                chk({nm, ".busy_done"}, 64'(done), 64'd0);
                chk({nm, ".busy_addr"}, dreq.addr, addr);
                chk({nm, ".busy_size"}, 64'(dreq.size), 64'(sz));
                chk({nm, ".busy_strobe"}, 64'(dreq.strobe),
                    wr ? 64'(m_strobe(nb, off)) : 64'd0);
                if (wr) chk({nm, ".busy_data"}, dreq.data, m_wdata(wd, off));
                next();
            end
            req_valid = 1'b0;
            flush     = 1'b0;
            dresp     = '0;
            #2;
            chk({nm, ".end_valid"}, 64'(dreq.valid), 64'd0);
            chk({nm, ".end_stall"}, 64'(stall), 64'd0);
            chk({nm, ".end_mis"}, 64'(misalign), 64'd0);
            if (dropped) begin
                chk({nm, ".drop_done"}, 64'(done), 64'd0);
            end else begin
                chk({nm, ".done"}, 64'(done), 64'd1);
                chk({nm, ".rdata"}, rdata, exp_rd);
            end
            next();
        end
    endtask

    initial begin
        resetn       = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 3'd0;
        req_unsigned = 1'b0;
        req_addr     = 64'd0;
        req_wdata    = 64'd0;
        flush        = 1'b0;
        dresp        = '0;
        #2;
        chk("rst.valid", 64'(dreq.valid), 64'd0);
        chk("rst.addr", dreq.addr, 64'd0);
        chk("rst.strobe", 64'(dreq.strobe), 64'd0);
        chk("rst.data", dreq.data, 64'd0);
        chk("rst.flags", 64'({stall, done, misalign}), 64'd0);
        chk("rst.rdata", rdata, 64'd0);
        next();
        next();
        resetn = 1'b1;
        next();

        // Directed scenarios.
        run_access("ld",  1'b0, 3'd3, 1'b0, 64'h80000008, 64'd0, 64'h1122334455667788, 3, 0);
        run_access("lb",  1'b0, 3'd0, 1'b0, 64'h80000003, 64'd0, 64'h0000000080FF0000, 2, 0);
        run_access("lbu", 1'b0, 3'd0, 1'b1, 64'h80000003, 64'd0, 64'h0000000080FF0000, 1, 0);
        run_access("lh",  1'b0, 3'd1, 1'b0, 64'h80000006, 64'd0, 64'hBEEF000000000000, 2, 0);
        run_access("sh",  1'b1, 3'd1, 1'b0, 64'h80000006, 64'hABCD, 64'h5A5A5A5A5A5A5A5A, 4, 0);
        run_access("lw_mis", 1'b0, 3'd2, 1'b0, 64'h80000002, 64'd0, 64'd0, 1, 0);
        run_access("flush", 1'b0, 3'd3, 1'b0, 64'h80000010, 64'd0, 64'hDEADBEEFCAFEF00D, 5, 2);
        run_access("after_flush", 1'b0, 3'd2, 1'b1, 64'h80000014, 64'd0, 64'hF234567800000000, 1, 0);

        // Flush in IDLE keeps the request out.
        req_valid = 1'b1;
        req_size  = 3'd3;
        req_addr  = 64'h80000020;
        flush     = 1'b1;
        #2;
        chk("idle_flush.stall", 64'(stall), 64'd0);
        next();
        req_valid = 1'b0;
        flush     = 1'b0;
        #2;
        chk("idle_flush.valid", 64'(dreq.valid), 64'd0);
        chk("idle_flush.done", 64'(done), 64'd0);
        next();

        // Reset while BUSY.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 3'd3;
        req_addr  = 64'h80000040;
        next();
        next();
        #2;
        chk("rst_busy.valid_pre", 64'(dreq.valid), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_busy.valid", 64'(dreq.valid), 64'd0);
        chk("rst_busy.stall", 64'(stall), 64'd0);
        chk("rst_busy.addr", dreq.addr, 64'd0);
        req_valid = 1'b0;
        next();
        resetn = 1'b1;
        next();
        #2;
        chk("rst_busy.idle", 64'({dreq.valid, done, stall}), 64'd0);
        next();
        run_access("sd", 1'b1, 3'd3, 1'b0, 64'h80000048, 64'h0123456789ABCDEF, 64'd0, 2, 0);

        // Randomized accesses.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  sz;
            int          lat;
            int          fl;
            sz  = 3'($urandom_range(0, 3));
            lat = $urandom_range(1, 4);
            fl  = 0;
            if (lat >= 2 && $urandom_range(0, 4) == 0) fl = $urandom_range(1, lat - 1);
            run_access("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                       {32'h00000000, 32'h80000000 | 32'($urandom_range(0, 255))},
                       {$urandom, $urandom}, {$urandom, $urandom}, lat, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
